// File: rtl/zion_bc_skid_pkg.sv
// -----------------------------------------------------------------------------
// zion_bc_skid_pkg
// Shared types and constants for the enable-qualified skid reader slice.
//   skid_state_e : occupancy state of the two-entry skid buffer
//   main_src_e   : source select for the main (output) data register
//   SKID_DEPTH   : number of word slots (main + skid)
//   OCC_W        : width needed to encode 0..SKID_DEPTH
//   occOf()      : maps a state to its word count
// Optional feature macro used by the top: ZION_BC_SKID_OCC_EN
// -----------------------------------------------------------------------------
package zion_bc_skid_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    typedef enum logic [1:0] {
        MAIN_SRC_IN   = 2'd0,
        MAIN_SRC_SKID = 2'd1,
        MAIN_SRC_INI  = 2'd2
    } main_src_e;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

    function automatic logic [OCC_W-1:0] occOf(input skid_state_e st);
        logic [OCC_W-1:0] occ;
        case (st)
            SKID_ONE:  occ = OCC_W'(1);
            SKID_FULL: occ = OCC_W'(2);
            default:   occ = '0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/zion_bc_skid_dat_reg.sv
// -----------------------------------------------------------------------------
// zion_bc_skid_dat_reg
// WIDTH-wide data register with load enable and synchronous active-high reset
// to INI_DATA. Used for both the main and skid slots of the skid reader.
// Ports:
//   clk  in  1      clock
//   rst  in  1      synchronous reset, active-high, loads INI_DATA
//   en   in  1      load enable
//   d    in  WIDTH  next value
//   q    out WIDTH  registered value
// -----------------------------------------------------------------------------
module zion_bc_skid_dat_reg #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= INI_DATA;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/zion_bc_en_skid_reader.sv
// -----------------------------------------------------------------------------
// zion_bc_en_skid_reader
// Read side of an enable-qualified register stage. Two-entry skid buffer
// (main + skid) between a valid/ready producer and consumer: full throughput
// when streaming, no word lost under backpressure, and both handshake outputs
// decoded from registered state only (no iVld->oRdy or iRdy->oVld path).
//
// Optional feature macro: ZION_BC_SKID_OCC_EN
//   defined   : adds oOcc (registered occupancy) and oOvf (sticky, set when
//               the producer offers a word while the buffer is full)
//   undefined : those ports are absent, core behaviour unchanged
//
// Ports:
//   clk   in   1      clock
//   rst   in   1      synchronous reset, active-high
//   iVld  in   1      upstream word valid
//   oRdy  out  1      upstream ready (state != FULL)
//   iDat  in   WIDTH  upstream data
//   oVld  out  1      downstream word valid (state != EMPTY)
//   iRdy  in   1      downstream ready
//   oDat  out  WIDTH  downstream data (main register; INI_DATA when empty)
//   oOcc  out  2      occupancy 0/1/2            (ZION_BC_SKID_OCC_EN only)
//   oOvf  out  1      sticky overflow attempt    (ZION_BC_SKID_OCC_EN only)
//
// State table:
//   state       | meaning
//   SKID_EMPTY  | no word held, oDat = INI_DATA
//   SKID_ONE    | main holds the head word
//   SKID_FULL   | main holds the head, skid holds the next word
// -----------------------------------------------------------------------------
module zion_bc_en_skid_reader
    import zion_bc_skid_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat
`ifdef ZION_BC_SKID_OCC_EN
    ,
    output logic [OCC_W-1:0] oOcc,
    output logic             oOvf
`endif
);

    skid_state_e      state;
    skid_state_e      stateNxt;
    main_src_e        mainSrc;
    logic             mainEn;
    logic             skidEn;
    logic             skidClr;
    logic             xferIn;
    logic             xferOut;
    logic [WIDTH-1:0] mainD;
    logic [WIDTH-1:0] mainQ;
    logic [WIDTH-1:0] skidD;
    logic [WIDTH-1:0] skidQ;

    assign oVld    = (state != SKID_EMPTY);
    assign oRdy    = (state != SKID_FULL);
    assign xferIn  = iVld && oRdy;
    assign xferOut = oVld && iRdy;
    assign oDat    = mainQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SKID_EMPTY;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        mainEn   = 1'b0;
        mainSrc  = MAIN_SRC_IN;
        skidEn   = 1'b0;
        skidClr  = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (xferIn) begin
                    stateNxt = SKID_ONE;
                    mainEn   = 1'b1;
                end
            end
            SKID_ONE: begin
                if (xferIn && !xferOut) begin
                    stateNxt = SKID_FULL;
                    skidEn   = 1'b1;
                end else if (xferIn && xferOut) begin
                    mainEn   = 1'b1;
                end else if (xferOut) begin
                    // Clearing main keeps oDat at INI_DATA whenever empty.
                    stateNxt = SKID_EMPTY;
                    mainEn   = 1'b1;
                    mainSrc  = MAIN_SRC_INI;
                end
            end
            SKID_FULL: begin
                // oRdy is low here, so only the drain of main can happen.
                if (xferOut) begin
                    stateNxt = SKID_ONE;
                    mainEn   = 1'b1;
                    mainSrc  = MAIN_SRC_SKID;
                    skidEn   = 1'b1;
                    skidClr  = 1'b1;
                end
            end
            default: begin
                stateNxt = SKID_EMPTY;
                mainEn   = 1'b1;
                mainSrc  = MAIN_SRC_INI;
                skidEn   = 1'b1;
                skidClr  = 1'b1;
            end
        endcase
    end

    always_comb begin
        mainD = INI_DATA;
        case (mainSrc)
            MAIN_SRC_IN:   mainD = iDat;
            MAIN_SRC_SKID: mainD = skidQ;
            default:       mainD = INI_DATA;
        endcase
    end

    assign skidD = skidClr ? INI_DATA : iDat;

    zion_bc_skid_dat_reg #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) uMainReg (
        .clk (clk),
        .rst (rst),
        .en  (mainEn),
        .d   (mainD),
        .q   (mainQ)
    );

    zion_bc_skid_dat_reg #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) uSkidReg (
        .clk (clk),
        .rst (rst),
        .en  (skidEn),
        .d   (skidD),
        .q   (skidQ)
    );

`ifdef ZION_BC_SKID_OCC_EN
    // Occupancy is registered from the next state so it tracks state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            oOcc <= '0;
            oOvf <= 1'b0;
        end else begin
            oOcc <= occOf(stateNxt);
            if (iVld && !oRdy) begin
                oOvf <= 1'b1;
            end
        end
    end
`endif

endmodule
